// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one 32-bit ALU with a registered response
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req0_* / req1_*            valid/ready request channels: a, b, op, tag
//   rsp_*                      valid/ready response: id, tag, result, zero, err
//   conflict_cnt               saturating count of cycles with both requesters valid
module alu_arbiter #(
    parameter int TAG_W      = 4,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic FIXED = (FIXED_PRIO != 0);

    logic             last_grant;
    logic             accept_en;
    logic             grant;
    logic             xfer;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [3:0]       sel_op;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      alu_result;
    logic             alu_err;
    logic             alu_zero;

    // The output register can take a new result when empty or draining this cycle.
    assign accept_en = !rst && (!rsp_valid || rsp_ready);

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = FIXED ? 1'b0 : ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = accept_en && !grant && req0_valid;
    assign req1_ready = accept_en &&  grant && req1_valid;
    assign xfer       = req0_ready || req1_ready;

    assign sel_a   = grant ? req1_a   : req0_a;
    assign sel_b   = grant ? req1_b   : req0_b;
    assign sel_op  = grant ? req1_op  : req0_op;
    assign sel_tag = grant ? req1_tag : req0_tag;

    always_comb begin
        alu_result = 32'd0;
        alu_err    = 1'b0;
        case (sel_op)
            4'b0000: alu_result = sel_a + sel_b;
            4'b0001: alu_result = sel_a - sel_b;
            4'b0010: alu_result = sel_a & sel_b;
            4'b0011: alu_result = sel_a | sel_b;
            4'b0100: alu_result = sel_a ^ sel_b;
            4'b0101: alu_result = sel_a << sel_b[4:0];
            4'b0110: alu_result = sel_a >> sel_b[4:0];
            4'b0111: alu_result = $unsigned($signed(sel_a) >>> sel_b[4:0]);
            4'b1000: alu_result = {31'd0, $signed(sel_a) < $signed(sel_b)};
            4'b1001: alu_result = {31'd0, sel_a < sel_b};
            default: alu_err    = 1'b1;
        endcase
    end

    // Illegal ops report zero=0 even though the result is forced to 0.
    assign alu_zero = !alu_err && (alu_result == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant;
            rsp_tag    <= sel_tag;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= alu_err;
            last_grant <= grant;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` between two requesters, e.g. the integer pipe (req0) and the address-generation path (req1).
- Each requester presents an operation with a valid/ready handshake.
- The block arbitrates round-robin, or fixed-priority when configured, and drives the granted operands into the ALU.
- It captures the result in a one-entry output register and returns it with the winner's ID and tag through a valid/ready response channel.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.
- FIXED_PRIO, 0, 0 = round-robin; 1 = req0 always wins a conflict.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  operand A.
- req0_b  input  32  operand B.
- req0_op  input  4  ALU control code.
- req0_tag  input  TAG_W  opaque tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_tag: same as req0, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_tag  output  TAG_W  tag of that operation.
- rsp_result  output  32  ALU result.
- rsp_zero  output  1  ALU zero flag.
- rsp_err  output  1  op code was illegal.
- conflict_cnt  output  CNT_W  cycles in which both requesters were valid; saturating.

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_zero=0, rsp_err=0, conflict_cnt=0.
  - last_grant=1, so req0 wins the first conflict.
  - req0_ready=req1_ready=0 while rst is high.
  - A reset mid-operation discards any held response; nothing is replayed.
- Accept enable: accept_en = !rst && (!rsp_valid || rsp_ready).
- Grant is combinational from the current valids:
  - Only one requester valid: that requester.
  - Both valid with FIXED_PRIO=1: req0.
  - Both valid with FIXED_PRIO=0: the requester that is not last_grant.
- reqN_ready = accept_en && grant==N && reqN_valid. At most one ready is high per cycle. Ready may depend on valid; requesters must not make valid depend on ready.
- A transfer occurs when reqN_valid && reqN_ready. On the next edge:
  - The response register loads rsp_valid=1, rsp_id=N, rsp_tag=reqN_tag.
  - It also loads the ALU outputs for reqN_a/b/op.
  - last_grant becomes N.
- last_grant is unchanged when no transfer occurs, including while stalled.
- Latency is 1 cycle from accepted request to rsp_valid.
- Throughput is 1 op/cycle while rsp_ready is held high: accept and drain in the same cycle.
- If rsp_ready=1 and no new transfer, rsp_valid clears on the next edge.
- Backpressure: while rsp_valid && !rsp_ready:
  - All response outputs hold stable.
  - Both readys are low.
  - A waiting requester must hold its valid and payload.
- Legal ops are 0000–1001:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift amount b[4:0].
  - 1000 SLT, 1001 SLTU.
- Illegal ops 1010–1111 are accepted and consume the grant, giving rsp_err=1, rsp_result=0, rsp_zero=0.
- conflict_cnt increments on every cycle with req0_valid && req1_valid, including stall cycles. It saturates at all-ones and does not wrap.
- A requester deasserting valid without a transfer is legal and has no effect on state.

Test Plan:
- req0 only: a=5, b=3, op=0000, rsp_ready=1 → req0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
- Both valid continuously for 4 cycles after reset, round-robin, req0 op=0001 a=5 b=3, req1 op=0010 a=F0F0F0F0 b=0F0F0F0F → responses alternate id 0,1,0,1 with results 2, 0 (zero=1), 2, 0; conflict_cnt=4. With FIXED_PRIO=1 the responses are all id 0.
- Backpressure: req1 SLT a=FFFFFFFF b=1, then rsp_ready=0 for 3 cycles while req0 is valid → rsp_result=1 held stable, req0_ready=0 throughout; req0 is accepted on the cycle rsp_ready returns high.
- Illegal op 1100 on req0 → rsp_err=1, rsp_result=0, rsp_zero=0; the next legal op SRA a=80000000 b=4 gives F8000000, err=0.
- Reset mid-operation: assert rst for 1 cycle while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0, conflict_cnt=0, readys low during rst; the next conflict is granted to req0.
- Saturation with CNT_W=4: both requesters valid for 20 cycles → conflict_cnt stops at 15.
